noc_packet_receiver: RTL and testbench

//  Ejection-side endpoint for one NoC node: sinks flits from NodeX_data_out/valid_out, drives NodeX_ready_out.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/noc_rx_packet_buffer.sv | 64 ++++++
 rtl/noc_packet_receiver.sv | 180 ++++++++++++++++++
 tb/tb_noc_packet_receiver.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared flit types, error codes and receiver FSM states for the NoC ejection endpoint.
package noc_pkg;

  localparam int unsigned TYPE_WIDTH = 2;

  localparam logic [1:0] FLIT_INVALID = 2'd0;
  localparam logic [1:0] FLIT_HEAD    = 2'd1;
  localparam logic [1:0] FLIT_BODY    = 2'd2;
  localparam logic [1:0] FLIT_TAIL    = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_FRAMING  = 2'd1;
  localparam logic [1:0] ERR_DEST     = 2'd2;
  localparam logic [1:0] ERR_LENGTH   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_SEND    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/noc_rx_packet_buffer.sv
// Payload store for one packet: FSM-indexed writes, registered read word and last flag.
module noc_rx_packet_buffer #(
  parameter int unsigned PAY_W = 30,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [PAY_W-1:0] wr_data_i,
  input  logic             start_i,
  input  logic             advance_i,
  output logic [PAY_W-1:0] rd_data_o,
  output logic             rd_last_o
);

  logic [PAY_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PAY_W-1:0] rd_data_q, rd_data_d;
  logic             last_q, last_d;
  logic [IDX_W-1:0] nxt_ptr;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  // Output word is pre-fetched into a register so the consumer sees a flop.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    last_d    = last_q;
    nxt_ptr   = rd_ptr_q + IDX_W'(1);
    if (start_i) begin
      rd_ptr_d  = '0;
      rd_data_d = (wr_en_i && (wr_idx_i == '0)) ? wr_data_i : mem_q[0];
      last_d    = (DEPTH == 1);
    end else if (advance_i) begin
      if (last_q) begin
        last_d = 1'b0;
      end else begin
        rd_ptr_d  = nxt_ptr;
        rd_data_d = mem_q[nxt_ptr];
        last_d    = (nxt_ptr == IDX_W'(DEPTH - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      last_q    <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      last_q    <= last_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_last_o = last_q;

endmodule

// File: rtl/noc_packet_receiver.sv
// NoC ejection endpoint: checks framing/destination/length and store-and-forwards payload.
// Optional NOC_RX_STATS_EN adds saturating good-packet and error counters.
module noc_packet_receiver #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TYPE_WIDTH    = 2,
  parameter int unsigned FlitPerPacket = 6,
  parameter int unsigned NODE_INDEX    = 0,
  parameter int unsigned DEST_WIDTH    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          flit_data_in,
  input  logic                           flit_valid_in,
  output logic                           flit_ready_in,
  output logic [DATA_WIDTH-TYPE_WIDTH-1:0] pkt_data,
  output logic                           pkt_valid,
  output logic                           pkt_last,
  input  logic                           pkt_ready,
  output logic                           err_valid,
  output logic [1:0]                     err_code
`ifdef NOC_RX_STATS_EN
  ,
  output logic [15:0]                    stat_pkts,
  output logic [15:0]                    stat_errs
`endif
);

  import noc_pkg::*;

  localparam int unsigned PAY_W    = DATA_WIDTH - TYPE_WIDTH;
  localparam int unsigned DEPTH    = FlitPerPacket - 1;
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAST_IDX = FlitPerPacket - 2;

  rx_state_e        state_q, state_d;
  rx_state_e        head_next;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ready_q, valid_q, err_valid_q;
  logic [1:0]       err_code_q, err_d;
  logic             wr_en, rd_start;
  logic [TYPE_WIDTH-1:0] ftype;
  logic             is_head, dest_ok, accept, deliver, cnt_full, buf_last;

  assign ftype    = flit_data_in[DATA_WIDTH-1 -: TYPE_WIDTH];
  assign is_head  = (ftype == TYPE_WIDTH'(FLIT_HEAD));
  assign dest_ok  = (flit_data_in[DEST_WIDTH-1:0] == DEST_WIDTH'(NODE_INDEX));
  assign accept   = flit_valid_in && ready_q;
  assign deliver  = valid_q && pkt_ready;
  assign cnt_full = (cnt_q == IDX_W'(LAST_IDX));

  // A head always starts a fresh packet; a mismatched one is swallowed up to its tail.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = ERR_NONE;
    wr_en     = 1'b0;
    rd_start  = 1'b0;
    head_next = dest_ok ? ST_RECV : ST_DISCARD;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_head) begin
            state_d = head_next;
            cnt_d   = '0;
            if (!dest_ok) err_d = ERR_DEST;
          end else begin
            err_d = ERR_FRAMING;
          end
        end
      end
      ST_RECV: begin
        if (accept) begin
          case (ftype)
            TYPE_WIDTH'(FLIT_HEAD): begin
              state_d = head_next;
              cnt_d   = '0;
              err_d   = ERR_FRAMING;
            end
            TYPE_WIDTH'(FLIT_BODY): begin
              if (cnt_full) begin
                err_d   = ERR_LENGTH;
                state_d = ST_DISCARD;
              end else begin
                wr_en = 1'b1;
                cnt_d = cnt_q + IDX_W'(1);
              end
            end
            TYPE_WIDTH'(FLIT_TAIL): begin
              if (cnt_full) begin
                wr_en    = 1'b1;
                rd_start = 1'b1;
                state_d  = ST_SEND;
              end else begin
                err_d   = ERR_LENGTH;
                state_d = ST_IDLE;
              end
            end
            default: begin
              err_d   = ERR_FRAMING;
              state_d = ST_DISCARD;
            end
          endcase
        end
      end
      ST_DISCARD: begin
        if (accept) begin
          if (is_head) begin
            state_d = head_next;
            cnt_d   = '0;
            err_d   = ERR_FRAMING;
          end else if (ftype == TYPE_WIDTH'(FLIT_TAIL)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SEND: begin
        if (deliver && buf_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= (state_d != ST_SEND);
      valid_q     <= (state_d == ST_SEND);
      err_valid_q <= (err_d != ERR_NONE);
      if (err_d != ERR_NONE) err_code_q <= err_d;
    end
  end

  noc_rx_packet_buffer #(
    .PAY_W (PAY_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (cnt_q),
    .wr_data_i (flit_data_in[PAY_W-1:0]),
    .start_i   (rd_start),
    .advance_i (deliver),
    .rd_data_o (pkt_data),
    .rd_last_o (buf_last)
  );

  assign flit_ready_in = ready_q;
  assign pkt_valid     = valid_q;
  assign pkt_last      = buf_last;
  assign err_valid     = err_valid_q;
  assign err_code      = err_code_q;

`ifdef NOC_RX_STATS_EN
  logic [15:0] stat_pkts_q, stat_errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_q <= '0;
      stat_errs_q <= '0;
    end else begin
      if (deliver && buf_last && (stat_pkts_q != 16'hFFFF)) stat_pkts_q <= stat_pkts_q + 16'd1;
      if ((err_d != ERR_NONE) && (stat_errs_q != 16'hFFFF)) stat_errs_q <= stat_errs_q + 16'd1;
    end
  end

  assign stat_pkts = stat_pkts_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_noc_packet_receiver.sv
// Directed + randomized bench for noc_packet_receiver against a packet-level reference model.
module tb_noc_packet_receiver;

  localparam int unsigned DW    = 32;
  localparam int unsigned PW    = 30;
  localparam int          FPP   = 6;
  localparam int unsigned NODE  = 4;
  localparam int unsigned DESTW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] flit_data_in;
  logic          flit_valid_in;
  logic          flit_ready_in;
  logic [PW-1:0] pkt_data;
  logic          pkt_valid, pkt_last, pkt_ready;
  logic          err_valid;
  logic [1:0]    err_code;
`ifdef NOC_RX_STATS_EN
  logic [15:0]   stat_pkts, stat_errs;
`endif

  always #5 clk = ~clk;

  noc_packet_receiver #(
    .DATA_WIDTH    (DW),
    .TYPE_WIDTH    (2),
    .FlitPerPacket (FPP),
    .NODE_INDEX    (NODE),
    .DEST_WIDTH    (DESTW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flit_data_in  (flit_data_in),
    .flit_valid_in (flit_valid_in),
    .flit_ready_in (flit_ready_in),
    .pkt_data      (pkt_data),
    .pkt_valid     (pkt_valid),
    .pkt_last      (pkt_last),
    .pkt_ready     (pkt_ready),
    .err_valid     (err_valid),
    .err_code      (err_code)
`ifdef NOC_RX_STATS_EN
    ,
    .stat_pkts     (stat_pkts),
    .stat_errs     (stat_errs)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_mode = 0;

  logic [PW:0]   exp_words[$], act_words[$];
  logic [1:0]    exp_err[$], act_err[$];
  int            mode;
  logic [PW-1:0] pay[$];
  int            exp_pkts, exp_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [PW-1:0] p);
    return {t, p};
  endfunction

  function automatic void push_err(input logic [1:0] c);
    exp_err.push_back(c);
    exp_errs++;
  endfunction

  // mode: 0 waiting for head, 1 collecting payload, 2 dropping until tail
  function automatic void start_head(input bit dok);
    mode = dok ? 1 : 2;
    pay.delete();
  endfunction

  function automatic void model_reset();
    mode = 0;
    pay.delete();
    exp_words.delete();
    exp_err.delete();
    exp_pkts = 0;
    exp_errs = 0;
  endfunction

  function automatic void model(input logic [DW-1:0] f);
    logic [1:0] t;
    bit dok;
    t   = f[DW-1 -: 2];
    dok = (f[DESTW-1:0] == DESTW'(NODE));
    case (mode)
      0: begin
        if (t == 2'd1) begin
          if (!dok) push_err(2'd2);
          start_head(dok);
        end else begin
          push_err(2'd1);
        end
      end
      1: begin
        case (t)
          2'd1: begin push_err(2'd1); start_head(dok); end
          2'd2: begin
            if (pay.size() == FPP - 2) begin push_err(2'd3); mode = 2; end
            else pay.push_back(f[PW-1:0]);
          end
          2'd3: begin
            pay.push_back(f[PW-1:0]);
            if (pay.size() == FPP - 1) begin
              foreach (pay[i]) exp_words.push_back({1'(i == pay.size() - 1), pay[i]});
              exp_pkts++;
            end else begin
              push_err(2'd3);
            end
            mode = 0;
          end
          default: begin push_err(2'd1); mode = 2; end
        endcase
      end
      default: begin
        if (t == 2'd1) begin push_err(2'd1); start_head(dok); end
        else if (t == 2'd3) mode = 0;
      end
    endcase
  endfunction

  // Output monitor: records deliveries/errors and checks hold-under-backpressure.
  logic          stall_q = 1'b0;
  logic [PW-1:0] stall_data;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 32'(pkt_valid), 32'd1);
        chk("hold_data", 32'(pkt_data), 32'(stall_data));
      end
      chk("ready_and_valid", 32'(flit_ready_in & pkt_valid), 32'd0);
      if (!pkt_valid) chk("last_without_valid", 32'(pkt_last), 32'd0);
      if (pkt_valid && pkt_ready) act_words.push_back({pkt_last, pkt_data});
      if (err_valid) act_err.push_back(err_code);
      stall_q    = pkt_valid && !pkt_ready;
      stall_data = pkt_data;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       pkt_ready = 1'b1;
      1:       pkt_ready = !pkt_ready;
      default: pkt_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_flit(input logic [DW-1:0] f);
    bit done = 1'b0;
    flit_valid_in = 1'b1;
    flit_data_in  = f;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (flit_ready_in) begin
        model(f);
        done = 1'b1;
      end
      cycle();
    end
    flit_valid_in = 1'b0;
    if (!done) chk("flit_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_good(input logic [PW-1:0] base);
    send_flit(mk(2'd1, PW'(NODE)));
    for (int i = 0; i < FPP - 2; i++) send_flit(mk(2'd2, base + PW'(i)));
    send_flit(mk(2'd3, base + PW'(FPP - 2)));
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    int nw, ne;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!pkt_valid && act_words.size() >= exp_words.size()) done = 1'b1;
      cycle();
    end
    repeat (3) cycle();
    chk({tag, "_drain"}, 32'(done), 32'd1);
    chk({tag, "_nwords"}, 32'(act_words.size()), 32'(exp_words.size()));
    chk({tag, "_nerrs"}, 32'(act_err.size()), 32'(exp_err.size()));
    nw = (act_words.size() < exp_words.size()) ? act_words.size() : exp_words.size();
    ne = (act_err.size() < exp_err.size()) ? act_err.size() : exp_err.size();
    for (int i = 0; i < nw; i++) chk({tag, "_word"}, 32'(act_words[i]), 32'(exp_words[i]));
    for (int i = 0; i < ne; i++) chk({tag, "_err"}, 32'(act_err[i]), 32'(exp_err[i]));
    act_words.delete();
    exp_words.delete();
    act_err.delete();
    exp_err.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(flit_ready_in), 32'd0);
    chk({tag, "_valid"}, 32'(pkt_valid), 32'd0);
    chk({tag, "_last"}, 32'(pkt_last), 32'd0);
    chk({tag, "_err_valid"}, 32'(err_valid), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] f;
    int dest, nbody, kind;

    // Reset
    rst = 1'b1; flit_valid_in = 1'b0; flit_data_in = '0; pkt_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
`ifdef NOC_RX_STATS_EN
    chk("reset_stat_pkts", 32'(stat_pkts), 32'd0);
    chk("reset_stat_errs", 32'(stat_errs), 32'd0);
`endif
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_during_release", 32'(flit_ready_in), 32'd0);
    cycle();
    @(negedge clk);
    chk("ready_after_release", 32'(flit_ready_in), 32'd1);
    cycle();

    // Good packet with latency checks
    send_flit(32'h4000_0004);
    for (int i = 0; i < 4; i++) send_flit(32'h8000_0042 + DW'(i));
    send_flit(32'hC000_0046);
    @(negedge clk);
    chk("lat_valid", 32'(pkt_valid), 32'd1);
    chk("lat_data", 32'(pkt_data), 32'h42);
    chk("send_ready", 32'(flit_ready_in), 32'd0);
    repeat (5) cycle();
    @(negedge clk);
    chk("done_valid", 32'(pkt_valid), 32'd0);
    chk("done_ready", 32'(flit_ready_in), 32'd1);
    cycle();
    wait_drain("good");

    // Destination mismatch
    send_flit(32'h4000_0005);
    for (int i = 0; i < 4; i++) send_flit(32'h8000_0050 + DW'(i));
    send_flit(32'hC000_0054);
    @(negedge clk);
    chk("dest_ready", 32'(flit_ready_in), 32'd1);
    chk("dest_code", 32'(err_code), 32'd2);
    chk("dest_valid", 32'(pkt_valid), 32'd0);
    cycle();
    wait_drain("dest");

    // Early tail, then a clean packet
    send_flit(32'h4000_0004);
    send_flit(32'h8000_0060);
    send_flit(32'h8000_0061);
    send_flit(32'hC000_0062);
    send_good(PW'(32'h100));
    wait_drain("early");

    // Backpressure with alternating consumer ready
    rdy_mode = 1;
    send_good(PW'(32'h200));
    wait_drain("bp");
    rdy_mode = 0;

    // Stray body, invalid type, duplicate head
    send_flit(mk(2'd2, PW'(32'h7)));
    send_flit(mk(2'd0, PW'(32'h8)));
    send_flit(32'h4000_0004);
    send_flit(32'h8000_0070);
    send_flit(32'h8000_0071);
    send_good(PW'(32'h80));
    @(negedge clk);
    chk("dup_last_code", 32'(err_code), 32'd1);
    cycle();
    wait_drain("dup");

    // Reset mid-RECV after three flits
    send_flit(32'h4000_0004);
    send_flit(32'h8000_0090);
    send_flit(32'h8000_0091);
    rst = 1'b1;
    cycle();
    cycle();
    @(negedge clk);
    check_reset_outputs("midrst");
`ifdef NOC_RX_STATS_EN
    chk("midrst_stat_pkts", 32'(stat_pkts), 32'd0);
    chk("midrst_stat_errs", 32'(stat_errs), 32'd0);
`endif
    model_reset();
    act_words.delete();
    act_err.delete();
    cycle();
    rst = 1'b0;
    send_good(PW'(32'h300));
    wait_drain("post_rst");

    // Randomized traffic with corruption and random consumer stalls
    rdy_mode = 2;
    for (int p = 0; p < 60; p++) begin
      kind  = int'($urandom_range(0, 9));
      dest  = (kind == 0) ? int'($urandom_range(0, 7)) : int'(NODE);
      nbody = (kind == 1) ? int'($urandom_range(0, 6)) : FPP - 2;
      if (kind == 2) send_flit(mk(2'd2, PW'($urandom)));
      for (int k = 0; k < nbody + 2; k++) begin
        if (k == 0)          f = mk(2'd1, PW'(dest));
        else if (k == nbody + 1) f = mk(2'd3, PW'($urandom));
        else                 f = mk(2'd2, PW'($urandom));
        if ($urandom_range(0, 19) == 0) f[DW-1 -: 2] = 2'($urandom);
        send_flit(f);
      end
    end
    wait_drain("rand");
    rdy_mode = 0;

`ifdef NOC_RX_STATS_EN
    chk("stat_pkts", 32'(stat_pkts), 32'(exp_pkts));
    chk("stat_errs", 32'(stat_errs), 32'(exp_errs));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
